// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: memory-stage load/store sequencer with lane formatting, misalignment and bus-timeout detection
module dmem_access_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic we_q, we_d, mis_q, mis_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] be_q, be_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] sel_q, sel_d;
  logic acc, legal, mis, tout;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [31:0] load_v;
  assign acc = mem_read_i | mem_write_i;
  assign legal = mem_write_i ? funct3_i inside {3'b000, 3'b001, 3'b010}
                             : funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign mis = (funct3_i[1:0] == 2'b01 && addr_i[0]) || (funct3_i == 3'b010 && addr_i[1:0] != 2'b00);
  assign tout = cnt_q >= CW'(TIMEOUT - 1);
  assign byte_v = dmem_rdata_i[{sel_q, 3'b000} +: 8];
  assign half_v = sel_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
  assign load_v = f3_q == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
                  f3_q == 3'b100 ? {24'd0, byte_v} :
                  f3_q == 3'b001 ? {{16{half_v[15]}}, half_v} :
                  f3_q == 3'b101 ? {16'd0, half_v} : dmem_rdata_i;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = we_q;
    mis_d = mis_q;
    err_d = err_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d = be_q;
    f3_d = f3_q;
    sel_d = sel_q;
    case (state_q)
      IDLE: begin
        if (acc && (!legal || mis)) begin
          state_d = DONE;
          mis_d = 1'b1;
          err_d = 1'b0;
        end else if (acc) begin
          state_d = REQ;
          mis_d = 1'b0;
          err_d = 1'b0;
          cnt_d = '0;
          we_d = mem_write_i;
          addr_d = {addr_i[31:2], 2'b00};
          sel_d = addr_i[1:0];
          f3_d = funct3_i;
          be_d = !mem_write_i ? 4'b1111 :
                 funct3_i == 3'b000 ? 4'b0001 << addr_i[1:0] :
                 funct3_i == 3'b001 ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
          wdata_d = funct3_i == 3'b000 ? {4{wdata_i[7:0]}} :
                    funct3_i == 3'b001 ? {2{wdata_i[15:0]}} : wdata_i;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (dmem_gnt_i) begin
          state_d = WAIT;
        end else if (tout) begin
          state_d = DONE;
          err_d = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (dmem_rvalid_i) begin
          state_d = DONE;
          rdata_d = we_q ? rdata_q : load_v;
        end else if (tout) begin
          state_d = DONE;
          err_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      mis_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q <= '0;
      f3_q <= '0;
      sel_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      mis_q <= mis_d;
      err_q <= err_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q <= be_d;
      f3_q <= f3_d;
      sel_q <= sel_d;
    end
  end
  assign stall_o = state_q == REQ || state_q == WAIT || (state_q == IDLE && acc);
  assign done_o = state_q == DONE;
  assign misaligned_o = state_q == DONE && mis_q;
  assign err_o = state_q == DONE && err_q;
  assign dmem_req_o = state_q == REQ;
  assign dmem_we_o = we_q;
  assign dmem_addr_o = addr_q;
  assign dmem_be_o = be_q;
  assign dmem_wdata_o = wdata_q;
  assign rdata_o = rdata_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed transaction bench with a cycle-timeline model of the access controller
module tb_dmem_access_ctrl;
  localparam int TO = 8;
  logic clk_i = 1'b0, rst_i = 1'b1, mem_read_i = 1'b0, mem_write_i = 1'b0;
  logic [2:0] funct3_i = '0;
  logic [31:0] addr_i = '0, wdata_i = '0, dmem_rdata_i = '0;
  logic dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic stall_o, done_o, misaligned_o, err_o, dmem_req_o, dmem_we_o;
  logic [31:0] rdata_o, dmem_addr_o, dmem_wdata_o;
  logic [3:0] dmem_be_o;
  dmem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o),
    .done_o(done_o), .rdata_o(rdata_o), .misaligned_o(misaligned_o), .err_o(err_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );
  always #5 clk_i = ~clk_i;
  int checks = 0, errors = 0;
  int n_req, n_done, n_mis, n_err, n_stall;
  logic chk_en = 1'b0;
  logic e_stall, e_done, e_mis, e_err, e_req, e_we;
  logic [31:0] e_addr, e_wdata, e_rdata, m_rdata = '0;
  logic [3:0] e_be;
  logic cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0] cap_be;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic set_exp(input logic s, input logic d, input logic m, input logic e, input logic r);
    e_stall = s;
    e_done = d;
    e_mis = m;
    e_err = e;
    e_req = r;
    e_rdata = m_rdata;
  endtask
  task automatic step;
    @(posedge clk_i);
    #1;
  endtask
  task automatic clr_cnt;
    n_req = 0;
    n_done = 0;
    n_mis = 0;
    n_err = 0;
    n_stall = 0;
  endtask
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("stall_o", 32'(stall_o), 32'(e_stall));
      check("done_o", 32'(done_o), 32'(e_done));
      check("misaligned_o", 32'(misaligned_o), 32'(e_mis));
      check("err_o", 32'(err_o), 32'(e_err));
      check("dmem_req_o", 32'(dmem_req_o), 32'(e_req));
      check("rdata_o", rdata_o, e_rdata);
      if (e_req) begin
        check("dmem_we_o", 32'(dmem_we_o), 32'(e_we));
        check("dmem_addr_o", dmem_addr_o, e_addr);
        check("dmem_be_o", 32'(dmem_be_o), 32'(e_be));
        check("dmem_wdata_o", dmem_wdata_o, e_wdata);
      end
      if (dmem_req_o) begin
        cap_we = dmem_we_o;
        cap_addr = dmem_addr_o;
        cap_be = dmem_be_o;
        cap_wdata = dmem_wdata_o;
      end
      n_req += int'(dmem_req_o);
      n_done += int'(done_o);
      n_mis += int'(misaligned_o);
      n_err += int'(err_o);
      n_stall += int'(stall_o);
    end
  end
  // gdly: REQ cycles before grant (-1 = never); rdly: WAIT cycles before rvalid
  task automatic access(input logic wr, input logic rd_also, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] w, input int gdly, input int rdly, input logic [31:0] word,
                        input logic late_rv);
    logic legal, bad, granted, fin, tout;
    logic [7:0] b;
    logic [15:0] h;
    logic [31:0] ld;
    int c;
    legal = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    bad = !legal || (f3[1:0] == 2'b01 && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
    e_we = wr;
    e_addr = a & ~32'd3;
    e_be = !wr ? 4'hF : f3 == 3'd0 ? 4'(1 << a[1:0]) : f3 == 3'd1 ? (a[1] ? 4'hC : 4'h3) : 4'hF;
    e_wdata = f3 == 3'd0 ? {4{w[7:0]}} : f3 == 3'd1 ? {2{w[15:0]}} : w;
    b = 8'(word >> (8 * int'(a[1:0])));
    h = 16'(word >> (16 * int'(a[1])));
    ld = f3 == 3'd0 ? 32'($signed(b)) : f3 == 3'd4 ? 32'(b) :
         f3 == 3'd1 ? 32'($signed(h)) : f3 == 3'd5 ? 32'(h) : word;
    mem_write_i = wr;
    mem_read_i = !wr || rd_also;
    funct3_i = f3;
    addr_i = a;
    wdata_i = w;
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i = 32'h5A5A5A5A;
    set_exp(1, 0, 0, 0, 0);
    step;
    if (bad) begin
      set_exp(0, 1, 1, 0, 0);
      step;
    end else begin
      c = 0;
      granted = 1'b0;
      fin = 1'b0;
      tout = 1'b0;
      while (!fin) begin
        if (!granted) begin
          dmem_gnt_i = (c == gdly);
          dmem_rvalid_i = 1'b0;
          set_exp(1, 0, 0, 0, 1);
          if (dmem_gnt_i) granted = 1'b1;
          else if (c == TO - 1) begin
            fin = 1'b1;
            tout = 1'b1;
          end
        end else begin
          dmem_gnt_i = 1'b0;
          dmem_rvalid_i = (c == gdly + 1 + rdly);
          dmem_rdata_i = dmem_rvalid_i ? word : 32'h5A5A5A5A;
          set_exp(1, 0, 0, 0, 0);
          if (dmem_rvalid_i) fin = 1'b1;
          else if (c >= TO - 1) begin
            fin = 1'b1;
            tout = 1'b1;
          end
        end
        step;
        c++;
      end
      dmem_gnt_i = 1'b0;
      dmem_rvalid_i = 1'b0;
      if (!tout && !wr) m_rdata = ld;
      set_exp(0, 1, 0, tout, 0);
      step;
    end
    mem_read_i = 1'b0;
    mem_write_i = 1'b0;
    dmem_rvalid_i = late_rv;
    dmem_rdata_i = 32'h11223344;
    set_exp(0, 0, 0, 0, 0);
    step;
    dmem_rvalid_i = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    clr_cnt();
    repeat (2) step;
    rst_i = 1'b0;
    set_exp(0, 0, 0, 0, 0);
    chk_en = 1'b1;
    check("reset dmem_addr_o", dmem_addr_o, 32'h0);
    check("reset dmem_be_o", 32'(dmem_be_o), 32'h0);
    check("reset dmem_we_o", 32'(dmem_we_o), 32'h0);
    step;
    clr_cnt();
    access(0, 0, 3'd2, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, 0);
    check("lw rdata", rdata_o, 32'hDEADBEEF);
    check("lw done pulses", n_done, 1);
    check("lw stall cycles", n_stall, 4);
    check("lw addr", cap_addr, 32'h100);
    check("lw be", 32'(cap_be), 32'hF);
    access(0, 0, 3'd0, 32'h103, 32'h0, 0, 0, 32'h80FF00AA, 0);
    check("lb rdata", rdata_o, 32'hFFFFFF80);
    access(0, 0, 3'd4, 32'h103, 32'h0, 1, 2, 32'h80FF00AA, 0);
    check("lbu rdata", rdata_o, 32'h00000080);
    clr_cnt();
    access(1, 0, 3'd1, 32'h202, 32'h1234ABCD, 1, 0, 32'hFFFFFFFF, 0);
    check("sh we", 32'(cap_we), 32'h1);
    check("sh be", 32'(cap_be), 32'hC);
    check("sh wdata", cap_wdata, 32'hABCDABCD);
    check("sh addr", cap_addr, 32'h200);
    check("sh rdata kept", rdata_o, 32'h00000080);
    check("sh done", n_done, 1);
    clr_cnt();
    access(0, 0, 3'd2, 32'h101, 32'h0, 0, 0, 32'h0, 0);
    check("mis pulses", n_mis, 1);
    check("mis no req", n_req, 0);
    check("mis rdata kept", rdata_o, 32'h00000080);
    clr_cnt();
    access(0, 0, 3'd2, 32'h104, 32'h0, -1, 0, 32'h0, 1);
    check("tout req cycles", n_req, TO);
    check("tout err pulses", n_err, 1);
    check("tout done pulses", n_done, 1);
    check("tout rdata kept", rdata_o, 32'h00000080);
    access(0, 0, 3'd1, 32'h102, 32'h0, 2, 0, 32'h80017FFF, 0);
    check("lh rdata", rdata_o, 32'hFFFF8001);
    access(0, 0, 3'd5, 32'h100, 32'h0, 0, 3, 32'h80017FFF, 0);
    check("lhu rdata", rdata_o, 32'h00007FFF);
    access(1, 0, 3'd0, 32'h101, 32'h00000055, 0, 0, 32'h0, 0);
    check("sb be", 32'(cap_be), 32'h2);
    check("sb wdata", cap_wdata, 32'h55555555);
    access(1, 1, 3'd2, 32'h10C, 32'hCAFE0001, 3, 2, 32'h0, 0);
    check("sw priority we", 32'(cap_we), 32'h1);
    access(0, 0, 3'd1, 32'h103, 32'h0, 0, 0, 32'h0, 0);
    access(0, 0, 3'd3, 32'h100, 32'h0, 0, 0, 32'h0, 0);
    access(1, 0, 3'd4, 32'h100, 32'h0, 0, 0, 32'h0, 0);
    access(0, 0, 3'd6, 32'h100, 32'h0, 0, 0, 32'h0, 0);
    clr_cnt();
    access(0, 0, 3'd2, 32'h108, 32'h0, 2, 20, 32'h0, 0);
    check("wait tout err", n_err, 1);
    access(0, 0, 3'd2, 32'h3F0, 32'h0, 0, 0, 32'h0BADF00D, 0);
    check("lw2 rdata", rdata_o, 32'h0BADF00D);
    mem_read_i = 1'b1;
    funct3_i = 3'd2;
    addr_i = 32'h300;
    set_exp(1, 0, 0, 0, 0);
    step;
    dmem_gnt_i = 1'b1;
    e_we = 1'b0;
    e_addr = 32'h300;
    e_be = 4'hF;
    e_wdata = dmem_wdata_o;
    set_exp(1, 0, 0, 0, 1);
    step;
    dmem_gnt_i = 1'b0;
    rst_i = 1'b1;
    set_exp(1, 0, 0, 0, 0);
    step;
    rst_i = 1'b0;
    mem_read_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'h77777777;
    m_rdata = 32'h0;
    set_exp(0, 0, 0, 0, 0);
    check("rst rdata", rdata_o, 32'h0);
    check("rst addr", dmem_addr_o, 32'h0);
    check("rst be", 32'(dmem_be_o), 32'h0);
    step;
    dmem_rvalid_i = 1'b0;
    step;
    check("post-rst rvalid ignored", rdata_o, 32'h0);
    access(0, 0, 3'd2, 32'h400, 32'h0, 0, 0, 32'h13579BDF, 0);
    check("post-rst lw", rdata_o, 32'h13579BDF);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequences data-memory loads and stores for the core's memory stage. It is driven by the decoded mem_read/mem_write strobes and the instruction's funct3. It runs a request/grant/response handshake toward the data memory, stalls the pipeline until the access completes, and returns size-formatted load data. It also flags misaligned or illegal accesses and bus timeouts.

Parameters:
TIMEOUT, 255, max cycles spent in REQ+WAIT before the access is aborted with err_o (counter width = clog2(TIMEOUT+1))

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
mem_read_i  in  1  load strobe from decode
mem_write_i  in  1  store strobe from decode
funct3_i  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
addr_i  in  32  byte address from ALU
wdata_i  in  32  store data (rs2)
stall_o  out  1  hold pipeline
done_o  out  1  one-cycle completion pulse
rdata_o  out  32  formatted load data
misaligned_o  out  1  one-cycle pulse: misaligned or illegal funct3
err_o  out  1  one-cycle pulse: bus timeout
dmem_req_o  out  1  bus request
dmem_we_o  out  1  bus write enable
dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  32  lane-replicated store data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  response valid (reads and writes)
dmem_rdata_i  in  32  read word

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: state=IDLE; all outputs 0; rdata_o=0; timeout counter=0. Reset mid-access aborts the access. A dmem_rvalid_i arriving after the reset is ignored.
- States: IDLE, REQ, WAIT, DONE.
- Access type: if mem_write_i and mem_read_i are both asserted, the access is a write. Write has priority.
- IDLE, no access: if mem_read_i=mem_write_i=0, stay in IDLE with stall_o=0.
- IDLE, access asserted: stall_o=1 combinationally in the same cycle.
  - Misaligned or illegal access -> DONE with misaligned_o set and no bus activity.
    - H/HU with addr[0]!=0 is misaligned.
    - W with addr[1:0]!=0 is misaligned.
    - funct3 outside the five listed codes is illegal (for stores, only 000/001/010 are legal).
  - Legal access -> REQ. Register we, addr, be and wdata at the transition.
- REQ:
  - dmem_req_o=1; we/addr/be/wdata stay stable until grant; stall_o=1.
  - On dmem_gnt_i -> WAIT and drop dmem_req_o the next cycle.
- WAIT:
  - stall_o=1.
  - On dmem_rvalid_i -> DONE. For reads, latch the formatted data into rdata_o. Writes leave rdata_o unchanged.
  - dmem_rvalid_i in the same cycle as the grant is not legal for the bus. dmem_rvalid_i outside WAIT is ignored.
- DONE:
  - done_o=1 and stall_o=0, so the pipeline advances this cycle.
  - misaligned_o or err_o pulse here if flagged.
  - Unconditional -> IDLE. Inputs seen in DONE belong to the retiring instruction. The minimum legal access is IDLE->REQ->WAIT->DONE = 4 cycles including the decode-visible cycle.
- Timeout:
  - Counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - On reaching TIMEOUT: dmem_req_o=0, go to DONE with err_o, and leave rdata_o unchanged.
- Load formatting, using byte lane sel=addr[1:0]:
  - B: sign-extend byte[sel].
  - BU: zero-extend byte[sel].
  - H: sign-extend halfword[addr[1]].
  - HU: zero-extend halfword[addr[1]].
  - W: full word.
- Store lanes:
  - SB: be=4'b0001<<sel, wdata={4{wdata_i[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{wdata_i[15:0]}}.
  - SW: be=1111, wdata=wdata_i.
  - For reads, dmem_be_o=1111 and dmem_we_o=0.
- rdata_o holds its last loaded value until the next successful load.

Test Plan:
- LW at addr 0x100, gnt on 1st REQ cycle, rvalid 2 cycles later with 0xDEADBEEF -> stall_o high until DONE, done_o pulses once, rdata_o=0xDEADBEEF, dmem_addr_o=0x100, be=1111.
- LB addr 0x103 and LBU addr 0x103, rdata word 0x80FF00AA -> LB gives rdata_o=0xFFFFFF80, LBU gives 0x00000080.
- SH addr 0x202, wdata_i=0x1234ABCD -> dmem_we_o=1, be=1100, dmem_wdata_o=0xABCDABCD, addr=0x200, completes on rvalid.
- LW addr 0x101 -> no dmem_req_o, misaligned_o and done_o pulse together in the 2nd cycle, rdata_o unchanged.
- Load with dmem_gnt_i held low and TIMEOUT=8 -> dmem_req_o high for 8 cycles, then err_o+done_o pulse. A late rvalid in IDLE is ignored.
- rst_i asserted during WAIT -> next cycle IDLE with all outputs 0. A following rvalid has no effect, and a new load completes normally.
